// File: rtl/jtpopeye_pkg.sv
// Shared types for the Popeye SDRAM arbiter: requester ids, FSM states and
// the default SDRAM placement of the OBJ ROM.
package jtpopeye_pkg;

    typedef enum logic [1:0] {
        ID_PROG,
        ID_OBJ,
        ID_MAIN
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } arb_state_e;

    localparam logic [21:0] OBJ_OFFSET_DEF = 22'h10_0000;

endpackage

// File: rtl/jtpopeye_sdram_cache1.sv
// One-entry read cache: tag, data and valid bit with a combinational hit flag.
// Invalidation takes precedence over a load in the same clock.
module jtpopeye_sdram_cache1 #(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inv,
    input  logic          load,
    input  logic [AW-1:0] load_tag,
    input  logic [DW-1:0] load_data,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          hit
);

    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            if (load) begin
                valid_q <= 1'b1;
                tag_q   <= load_tag;
                data_q  <= load_data;
            end
            if (inv) valid_q <= 1'b0;
        end
    end

    assign hit  = valid_q && (tag_q == addr);
    assign data = data_q;

endmodule

// File: rtl/jtpopeye_sdram_arb.sv
// Arbitrates the single SDRAM port between ROM download writes, OBJ line
// fetches and main CPU ROM reads, with a one-entry cache per reader.
module jtpopeye_sdram_arb
    import jtpopeye_pkg::*;
#(
    parameter int                  MAIN_AW    = 15,
    parameter int                  OBJ_AW     = 13,
    parameter int                  SDRAM_AW   = 22,
    parameter logic [SDRAM_AW-1:0] OBJ_OFFSET = SDRAM_AW'(OBJ_OFFSET_DEF),
    parameter int                  STARVE     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic                prog_we,
    input  logic [SDRAM_AW-1:0] prog_addr,
    input  logic [15:0]         prog_data,
    input  logic                main_cs,
    input  logic [MAIN_AW-1:0]  main_addr,
    output logic [7:0]          main_dout,
    output logic                main_ok,
    input  logic                obj_cs,
    input  logic [OBJ_AW-1:0]   obj_addr,
    output logic [31:0]         obj_data,
    output logic                obj_ok,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic                sdram_rd,
    output logic                sdram_wr,
    output logic [15:0]         sdram_din,
    input  logic                sdram_ack,
    input  logic                sdram_rdy,
    input  logic [31:0]         sdram_dout
);

    localparam int MTW = MAIN_AW - 2;
    localparam int SW  = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    arb_state_e          state_q;
    req_id_e             id_q;
    logic [SDRAM_AW-1:0] addr_q;
    logic                rd_q, wr_q;
    logic [15:0]         din_q;
    logic [SW-1:0]       starve_q, starve_d;
    logic                prog_pend_q;
    logic [SDRAM_AW-1:0] prog_addr_q;
    logic [15:0]         prog_data_q;
    logic [MTW-1:0]      main_lat_q;
    logic [OBJ_AW-1:0]   obj_lat_q;

    logic                main_hit, obj_hit, main_miss, obj_miss;
    logic                go_main, go_obj, main_load, obj_load;
    logic [31:0]         main_word;
    logic [SDRAM_AW-1:0] main_req_addr, obj_req_addr;

    assign main_miss = main_cs && !main_hit;
    assign obj_miss  = obj_cs && !obj_hit;
    // A starved main request overtakes OBJ; otherwise OBJ goes first.
    assign go_main   = !downloading && main_miss && (starve_q == STARVE_MAX || !obj_miss);
    assign go_obj    = !downloading && obj_miss && !(main_miss && starve_q == STARVE_MAX);
    assign starve_d  = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);

    assign main_req_addr = {{(SDRAM_AW-MAIN_AW+1){1'b0}}, main_addr[MAIN_AW-1:2], 1'b0};
    assign obj_req_addr  = OBJ_OFFSET + {{(SDRAM_AW-OBJ_AW-1){1'b0}}, obj_addr, 1'b0};

    assign main_load = (state_q == ST_WAIT) && sdram_rdy && (id_q == ID_MAIN);
    assign obj_load  = (state_q == ST_WAIT) && sdram_rdy && (id_q == ID_OBJ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            id_q        <= ID_PROG;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            din_q       <= '0;
            starve_q    <= '0;
            prog_pend_q <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            main_lat_q  <= '0;
            obj_lat_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (prog_pend_q) begin
                        wr_q        <= 1'b1;
                        addr_q      <= prog_addr_q;
                        din_q       <= prog_data_q;
                        id_q        <= ID_PROG;
                        prog_pend_q <= 1'b0;
                        state_q     <= ST_REQ;
                    end else if (go_main) begin
                        rd_q       <= 1'b1;
                        addr_q     <= main_req_addr;
                        id_q       <= ID_MAIN;
                        main_lat_q <= main_addr[MAIN_AW-1:2];
                        starve_q   <= '0;
                        state_q    <= ST_REQ;
                    end else if (go_obj) begin
                        rd_q      <= 1'b1;
                        addr_q    <= obj_req_addr;
                        id_q      <= ID_OBJ;
                        obj_lat_q <= obj_addr;
                        starve_q  <= starve_d;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= wr_q ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sdram_rdy) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            // A fresh strobe overrides a pending one, including one served now.
            if (prog_we) begin
                prog_pend_q <= 1'b1;
                prog_addr_q <= prog_addr;
                prog_data_q <= prog_data;
            end
        end
    end

    jtpopeye_sdram_cache1 #(.AW(MTW), .DW(32)) u_main_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .inv       (downloading),
        .load      (main_load),
        .load_tag  (main_lat_q),
        .load_data (sdram_dout),
        .addr      (main_addr[MAIN_AW-1:2]),
        .data      (main_word),
        .hit       (main_hit)
    );

    jtpopeye_sdram_cache1 #(.AW(OBJ_AW), .DW(32)) u_obj_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .inv       (downloading),
        .load      (obj_load),
        .load_tag  (obj_lat_q),
        .load_data (sdram_dout),
        .addr      (obj_addr),
        .data      (obj_data),
        .hit       (obj_hit)
    );

    always_comb begin
        main_dout = main_word[7:0];
        case (main_addr[1:0])
            2'd1:    main_dout = main_word[15:8];
            2'd2:    main_dout = main_word[23:16];
            2'd3:    main_dout = main_word[31:24];
            default: main_dout = main_word[7:0];
        endcase
    end

    assign main_ok    = main_cs && main_hit;
    assign obj_ok     = obj_cs && obj_hit;
    assign sdram_addr = addr_q;
    assign sdram_rd   = rd_q;
    assign sdram_wr   = wr_q;
    assign sdram_din  = din_q;

endmodule

// File: tb/tb_jtpopeye_sdram_arb.sv
// Directed bench: expected SDRAM requests are queued as stimulus is applied
// and popped as the arbiter issues them; cache outputs are checked directly.
module tb_jtpopeye_sdram_arb;

    typedef struct {
        logic [21:0] addr;
        logic        wr;
        logic [15:0] din;
        logic [31:0] rdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0, prog_we = 1'b0;
    logic [21:0] prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        main_cs = 1'b0, obj_cs = 1'b0;
    logic [14:0] main_addr = '0;
    logic [12:0] obj_addr = '0;
    logic [7:0]  main_dout;
    logic        main_ok, obj_ok;
    logic [31:0] obj_data;
    logic [21:0] sdram_addr;
    logic        sdram_rd, sdram_wr;
    logic [15:0] sdram_din;
    logic        sdram_ack = 1'b0, sdram_rdy = 1'b0;
    logic [31:0] sdram_dout = '0;

    int   checks = 0, failures = 0;
    req_t sb[$];

    always #5 clk = ~clk;

    jtpopeye_sdram_arb dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .main_cs(main_cs), .main_addr(main_addr), .main_dout(main_dout), .main_ok(main_ok),
        .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
        .sdram_din(sdram_din), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
        .sdram_dout(sdram_dout)
    );

    function automatic logic [21:0] main_map(input logic [14:0] a);
        return {8'd0, a[14:2], 1'b0};
    endfunction

    function automatic logic [21:0] obj_map(input logic [12:0] a);
        return 22'h10_0000 + {8'd0, a, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rd(input logic [21:0] a, input logic [31:0] d);
        req_t e;
        e.addr = a; e.wr = 1'b0; e.din = '0; e.rdata = d;
        sb.push_back(e);
    endtask

    // mode 0: normal, 1: move obj_addr to nobj before rdy, 2: reset while in WAIT
    task automatic serve(input int mode, input logic [12:0] nobj);
        req_t e;
        int   n = 0;
        while (!(sdram_rd || sdram_wr) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {63'd0, sdram_rd | sdram_wr}, 64'd1);
        if (!(sdram_rd || sdram_wr)) return;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check("req_addr", {42'd0, sdram_addr}, {42'd0, e.addr});
        check("req_wr", {63'd0, sdram_wr}, {63'd0, e.wr});
        if (e.wr) check("req_din", {48'd0, sdram_din}, {48'd0, e.din});
        @(negedge clk);
        check("req_hold", {41'd0, sdram_rd | sdram_wr, sdram_addr}, {41'd1, e.addr});
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        check("req_drop", {63'd0, sdram_rd | sdram_wr}, 64'd0);
        if (e.wr) return;
        if (mode == 2) begin
            rst_n = 1'b0;
            #1;
            check("rst_rd", {63'd0, sdram_rd}, 64'd0);
            check("rst_main_ok", {63'd0, main_ok}, 64'd0);
            check("rst_obj_ok", {63'd0, obj_ok}, 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            sdram_dout = e.rdata;
            sdram_rdy = 1'b1;
            @(negedge clk);
            sdram_rdy = 1'b0;
            check("late_rdy_main_ok", {63'd0, main_ok}, 64'd0);
            return;
        end
        if (mode == 1) obj_addr = nobj;
        sdram_dout = e.rdata;
        sdram_rdy = 1'b1;
        @(negedge clk);
        sdram_rdy = 1'b0;
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (sdram_rd || sdram_wr) seen = 1'b1;
        end
        check(tag, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        bit pat[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        req_t w;

        // reset values
        @(negedge clk);
        check("rst_outputs", {sdram_rd, sdram_wr, main_ok, obj_ok, 60'd0},
              64'd0);
        check("rst_addr_din", {26'd0, sdram_addr, sdram_din}, 64'd0);
        check("rst_data", {24'd0, main_dout, obj_data}, 64'd0);

        // reset during WAIT, then a late rdy must not fill the cache
        rst_n = 1'b1;
        main_cs = 1'b1;
        main_addr = 15'h0123;
        push_rd(main_map(main_addr), 32'hDDCC_BBAA);
        serve(2, '0);

        // main miss after reset, byte select, hits without SDRAM traffic
        push_rd(main_map(main_addr), 32'hDDCC_BBAA);
        serve(0, '0);
        check("main_ok", {63'd0, main_ok}, 64'd1);
        check("main_dout_b3", {56'd0, main_dout}, 64'hDD);
        main_addr = 15'h0120; #1;
        check("main_dout_b0", {55'd0, main_ok, main_dout}, 64'h1AA);
        main_addr = 15'h0121; #1;
        check("main_dout_b1", {55'd0, main_ok, main_dout}, 64'h1BB);
        main_cs = 1'b0; #1;
        check("main_cs_low", {63'd0, main_ok}, 64'd0);
        main_cs = 1'b1;
        main_addr = 15'h0123;
        expect_idle("main_hit_no_req", 8);

        // download write, reads blocked, tags cleared
        downloading = 1'b1;
        prog_we = 1'b1;
        prog_addr = 22'h00_0040;
        prog_data = 16'h1234;
        w.addr = 22'h00_0040; w.wr = 1'b1; w.din = 16'h1234; w.rdata = '0;
        sb.push_back(w);
        @(negedge clk);
        prog_we = 1'b0;
        check("dl_main_ok", {63'd0, main_ok}, 64'd0);
        serve(0, '0);
        expect_idle("dl_reads_blocked", 6);
        downloading = 1'b0; #1;
        check("post_dl_miss", {63'd0, main_ok}, 64'd0);
        push_rd(main_map(main_addr), 32'h1122_3344);
        serve(0, '0);
        check("post_dl_dout", {55'd0, main_ok, main_dout}, 64'h111);

        // OBJ address mapping
        main_cs = 1'b0;
        obj_cs = 1'b1;
        obj_addr = 13'h0005;
        push_rd(obj_map(obj_addr), 32'hCAFE_F00D);
        serve(0, '0);
        check("obj_data", {31'd0, obj_ok, obj_data}, {31'd1, 32'hCAFE_F00D});

        // address moves while waiting: stale fill, new request follows
        obj_addr = 13'h0006;
        push_rd(obj_map(obj_addr), 32'h0101_0101);
        serve(1, 13'h0007);
        check("obj_stale_ok", {63'd0, obj_ok}, 64'd0);
        push_rd(obj_map(13'h0007), 32'h7777_7777);
        serve(0, '0);
        check("obj_new_data", {31'd0, obj_ok, obj_data}, {31'd1, 32'h7777_7777});

        // main-only grant resets the starvation count
        obj_cs = 1'b0;
        main_cs = 1'b1;
        main_addr = 15'h0200;
        push_rd(main_map(main_addr), 32'h5555_5555);
        serve(0, '0);

        // both missing: obj, obj, obj, main, obj
        main_addr = 15'h0300;
        obj_cs = 1'b1;
        obj_addr = 13'h0100;
        for (int i = 0; i < 5; i++) begin
            if (pat[i]) begin
                push_rd(main_map(main_addr), 32'hA000_0000 + i);
                serve(0, '0);
                main_addr = main_addr + 15'd4;
            end else begin
                push_rd(obj_map(obj_addr), 32'hB000_0000 + i);
                serve(0, '0);
                obj_addr = obj_addr + 13'd1;
            end
        end
        obj_cs = 1'b0;
        main_cs = 1'b0;

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
